// File: rtl/apb_pkg.sv
// Shared APB types and default bus widths for the requester and slave.
// No logic, no latency, no backpressure.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter: expired is high once LIMIT stalled cycles have elapsed since clear.
// Registered count, combinational compare; saturates at LIMIT, no backpressure.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt >= LIMIT_C);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_master_fsm.sv
// APB requester: one command at a time through SETUP/ACCESS, 3-cycle min latency to rsp_valid.
// cmd_ready only in IDLE; ACCESS stalls on pready=0 (bounded by a timer with APB_TIMEOUT_EN).
module apb_master_fsm
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_t state;
    logic       expired;

    assign cmd_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !pready),
        .expired (expired)
    );
`else
    wire unused_timeout = |TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state  <= SETUP;
                        psel   <= 1'b1;
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // pready wins over a coincident timeout
                    if (pready) begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= 1'b0;
                    end else if (expired) begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
